// File: rtl/riscv_pkg.sv
// Shared core parameters and the program-loader state encoding.
package riscv_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned MEM_SIZE         = 1024;
  localparam int unsigned LOADER_MAX_WORDS = MEM_SIZE;

  typedef enum logic [2:0] {
    LdIdle,
    LdLen,
    LdData,
    LdCheck,
    LdDone,
    LdErr
  } loader_state_e;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles little-endian words from a byte source,
// writes them to sequential instruction-memory addresses and verifies a trailing
// checksum. Holds the core while loading and after a rejected image.
module imem_loader #(
  parameter int unsigned XLEN     = riscv_pkg::XLEN,  // must be 32
  parameter int unsigned MEM_SIZE = riscv_pkg::MEM_SIZE,
  parameter int unsigned AW       = $clog2(MEM_SIZE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            byte_valid,
  input  logic [7:0]      byte_data,
  output logic            byte_ready,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            core_hold,
  output logic            busy,
  output logic            done,
  output logic            error
);
  import riscv_pkg::*;

  loader_state_e   state_q;
  logic [1:0]      byte_cnt_q;
  logic [XLEN-1:0] shift_q;
  logic [XLEN-1:0] sum_q;
  // One extra bit so a full-memory image (N == MEM_SIZE) fits.
  logic [AW:0]     len_q;
  logic [AW:0]     word_idx_q;

  logic            byte_fire;
  logic            field_done;
  logic [XLEN-1:0] field_word;
  logic [AW:0]     idx_inc;

  assign byte_fire  = byte_valid & byte_ready;
  assign field_done = byte_fire & (byte_cnt_q == 2'd3);
  // Shift right so byte k of a field ends up in bits [8k+7:8k].
  assign field_word = {byte_data, shift_q[XLEN-1:8]};
  assign idx_inc    = word_idx_q + {{AW{1'b0}}, 1'b1};

  // Loader FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LdIdle;
      byte_cnt_q <= 2'd0;
      shift_q    <= '0;
      sum_q      <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_hold  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      unique case (state_q)
        LdIdle, LdDone, LdErr: begin
          if (start) begin
            state_q    <= LdLen;
            byte_cnt_q <= 2'd0;
            sum_q      <= '0;
            word_idx_q <= '0;
            byte_ready <= 1'b1;
            core_hold  <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
          end
        end
        LdLen, LdData, LdCheck: begin
          if (byte_fire) begin
            shift_q    <= field_word;
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
          if (field_done) begin
            unique case (state_q)
              LdLen: begin
                len_q <= field_word[AW:0];
                if (field_word > MEM_SIZE) begin
                  state_q    <= LdErr;
                  byte_ready <= 1'b0;
                  busy       <= 1'b0;
                  error      <= 1'b1;
                end else if (field_word == '0) begin
                  state_q <= LdCheck;
                end else begin
                  state_q <= LdData;
                end
              end
              LdData: begin
                mem_we     <= 1'b1;
                mem_addr   <= word_idx_q[AW-1:0];
                mem_wdata  <= field_word;
                sum_q      <= sum_q + field_word;
                word_idx_q <= idx_inc;
                if (idx_inc == len_q) state_q <= LdCheck;
              end
              default: begin
                byte_ready <= 1'b0;
                busy       <= 1'b0;
                if (field_word == sum_q) begin
                  state_q   <= LdDone;
                  core_hold <= 1'b0;
                  done      <= 1'b1;
                end else begin
                  state_q <= LdErr;
                  error   <= 1'b1;
                end
              end
            endcase
          end
        end
        default: state_q <= LdIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

  localparam int unsigned AW = 10;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        error;

  int n_cmp = 0;
  int n_fail = 0;

  int            wr_count = 0;
  logic [AW-1:0] wr_addr_log[64];
  logic [31:0]   wr_data_log[64];

  imem_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Log every write strobe seen mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (wr_count < 64) begin
        wr_addr_log[wr_count] <= mem_addr;
        wr_data_log[wr_count] <= mem_wdata;
      end
      wr_count <= wr_count + 1;
    end
  end

  function automatic bq_t good_image();
    bq_t q;
    q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
          8'h13, 8'h01, 8'h10, 8'h00, 8'hA6, 8'h01, 8'h60, 8'h00};
    return q;
  endfunction

  task automatic check_flags(input string name, input logic e_ready, input logic e_hold,
                             input logic e_busy, input logic e_done, input logic e_err);
    logic [4:0] got, exp;
    got = {byte_ready, core_hold, busy, done, error};
    exp = {e_ready, e_hold, e_busy, e_done, e_err};
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: {ready,hold,busy,done,error} got %b expected %b", name, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_flags("start_latency", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  // Send bytes, checking the write strobe right after every accepting edge.
  task automatic send_stream(input bq_t b, input int n_words, input bit gaps,
                             input int start_at);
    logic        exp_we;
    logic [31:0] exp_w;
    for (int j = 0; j < b.size(); j++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          byte_valid = 1'b0;
          @(posedge clk); #1;
          n_cmp++;
          if (mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_we: byte %0d got %b expected 0", j, mem_we);
          end
        end
      end
      byte_valid = 1'b1;
      byte_data  = b[j];
      start      = (j == start_at);
      @(posedge clk); #1;
      byte_valid = 1'b0;
      start      = 1'b0;
      exp_we = (j >= 4) && (j < 4 + 4 * n_words) && ((j % 4) == 3);
      n_cmp++;
      if (mem_we !== exp_we) begin
        n_fail++;
        $display("FAIL stream_we: byte %0d got %b expected %b", j, mem_we, exp_we);
      end
      if (exp_we) begin
        exp_w = {b[j], b[j-1], b[j-2], b[j-3]};
        n_cmp++;
        if (mem_addr !== AW'((j - 4) / 4) || mem_wdata !== exp_w) begin
          n_fail++;
          $display("FAIL stream_write: byte %0d got %0d/%h expected %0d/%h",
                   j, mem_addr, mem_wdata, (j - 4) / 4, exp_w);
        end
      end
    end
  endtask

  task automatic check_writes(input string name, input int base, input int n,
                              input logic [31:0] w0, input logic [31:0] w1);
    n_cmp++;
    if (wr_count - base !== n) begin
      n_fail++;
      $display("FAIL %s_count: got %0d expected %0d", name, wr_count - base, n);
    end else if (n == 2) begin
      n_cmp++;
      if (wr_addr_log[base] !== 10'd0 || wr_data_log[base] !== w0 ||
          wr_addr_log[base+1] !== 10'd1 || wr_data_log[base+1] !== w1) begin
        n_fail++;
        $display("FAIL %s_data: got %0d=%h %0d=%h expected 0=%h 1=%h", name,
                 wr_addr_log[base], wr_data_log[base], wr_addr_log[base+1],
                 wr_data_log[base+1], w0, w1);
      end
    end
  endtask

  task automatic test_reset();
    int base;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_flags("reset_flags", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_mem: got %b/%h/%h expected 0/0/0", mem_we, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    base = wr_count;
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    check_flags("idle_ignores_bytes", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_writes("idle_writes", base, 0, '0, '0);
  endtask

  task automatic test_two_word();
    int base;
    base = wr_count;
    pulse_start();
    send_stream(good_image(), 2, 1'b0, -1);
    check_flags("two_word_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    n_cmp++;
    if (mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL two_word_we_after: got %b expected 0", mem_we);
    end
    check_writes("two_word", base, 2, 32'h00500093, 32'h00100113);
  endtask

  task automatic test_bad_checksum();
    int  base;
    bq_t img;
    base = wr_count;
    img = good_image();
    img[15] = 8'h01;
    pulse_start();
    send_stream(img, 2, 1'b0, -1);
    check_flags("bad_csum_err", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_flags("bad_csum_hold", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check_writes("bad_csum", base, 2, 32'h00500093, 32'h00100113);
  endtask

  task automatic test_len_overflow();
    int  base;
    bq_t img;
    base = wr_count;
    img = '{8'h01, 8'h04, 8'h00, 8'h00};
    pulse_start();
    send_stream(img, 0, 1'b0, -1);
    check_flags("overflow_err", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check_writes("overflow", base, 0, '0, '0);
    // N == MEM_SIZE is the largest legal length: must enter DATA.
    img = '{8'h00, 8'h04, 8'h00, 8'h00};
    pulse_start();
    send_stream(img, 0, 1'b0, -1);
    check_flags("max_len_data", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_empty(input bit gaps);
    int  base;
    bq_t img;
    base = wr_count;
    img = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    pulse_start();
    send_stream(img, 0, gaps, -1);
    check_flags(gaps ? "empty_gaps_done" : "empty_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_writes(gaps ? "empty_gaps" : "empty", base, 0, '0, '0);
  endtask

  task automatic test_start_ignored_gaps();
    int base;
    base = wr_count;
    pulse_start();
    send_stream(good_image(), 2, 1'b1, 6);
    check_flags("start_ignored_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_writes("start_ignored", base, 2, 32'h00500093, 32'h00100113);
  endtask

  task automatic test_reset_mid_data();
    int  base;
    bq_t img;
    bq_t part;
    base = wr_count;
    img = good_image();
    part = img[0:5];
    pulse_start();
    send_stream(part, 2, 1'b0, -1);
    #2;
    rst = 1'b1;
    #1;
    check_flags("mid_reset_flags", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_writes("mid_reset", base, 0, '0, '0);
    base = wr_count;
    pulse_start();
    send_stream(img, 2, 1'b0, -1);
    check_flags("after_reset_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_writes("after_reset", base, 2, 32'h00500093, 32'h00100113);
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_bad_checksum();
    test_len_overflow();
    test_empty(1'b0);
    test_empty(1'b1);
    test_start_ignored_gaps();
    test_reset_mid_data();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Write-side counterpart of the instruction memory: accepts a byte stream carrying a program image, assembles little-endian 32-bit words and drives the memory's write port with sequential word addresses. Holds the core stalled while loading, and keeps it stalled if the image is rejected. Sits between a byte source (UART receiver, debug bridge, testbench) and the instruction memory write port, alongside the core's combinational fetch path.

## Interface
- `XLEN` — default `riscv_pkg::XLEN` (32). Word width; the block requires exactly 32.
- `MEM_SIZE` — default `riscv_pkg::MEM_SIZE` (1024). Memory depth in words.
- `AW` — default `$clog2(MEM_SIZE)`. Word-address width; this is the same index fetch uses, `pc[AW+1:2]`.

Ports:
- `clk` in 1: single clock. Reset is asynchronous and active-high.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to begin a load. Honoured only in IDLE, DONE or ERR.
- `byte_valid` in 1: source has a byte.
- `byte_data` in 8: stream byte.
- `byte_ready` out 1: loader accepts a byte. A byte transfers when `byte_valid && byte_ready`.
- `mem_we` out 1: one-cycle write strobe.
- `mem_addr` out AW: word index of the write.
- `mem_wdata` out XLEN: word to write.
- `core_hold` out 1: stall/reset request to the core.
- `busy` out 1: high in LEN, DATA, CHECK.
- `done` out 1: level, high in DONE.
- `error` out 1: level, high in ERR.

## Operation
Image format, all fields little-endian 32-bit:
- Word count N.
- N instruction words.
- Checksum equal to the sum of all N words, mod 2^32.

States:
- **IDLE:** `byte_ready`=0. `start` moves to LEN.
- **LEN:** collect 4 bytes into N.
  - N > MEM_SIZE → ERR.
  - N == 0 → CHECK.
  - Otherwise → DATA.
- **DATA:** collect 4 bytes per word.
  - On the 4th byte, register the word and issue a write at `word_idx`.
  - `word_idx` increments and the sum accumulates.
  - After word N-1 → CHECK.
- **CHECK:** collect 4 bytes. Equal to the sum → DONE, else → ERR.
- **DONE / ERR:** `byte_ready`=0. `start` restarts at LEN with the counter, word index and sum cleared.

Rules:
- `start` in LEN, DATA or CHECK is ignored.
- `byte_ready`=1 in LEN, DATA and CHECK. There is no backpressure from memory: writes always complete in one cycle.
- Byte lane: the k-th byte of a field (k = 0..3) fills bits [8k+7:8k].
- Byte counter: 2 bits, wraps 3→0 on each completed field.
- `core_hold`=1 in LEN, DATA, CHECK and ERR; 0 in IDLE and DONE.
- The sum is a 32-bit wrapping add.
- An ERR entered from LEN performs no writes.
- An ERR entered from CHECK leaves the written words in memory; `core_hold` remains high.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE
  - `byte_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0
  - `core_hold`=0, `busy`=0, `done`=0, `error`=0
- Reset mid-load aborts immediately to IDLE. No further writes occur, and the partially written memory is not cleared.
- `start` sampled in cycle t → state LEN, `busy`=1, `core_hold`=1 and `byte_ready`=1 in t+1.
- 4th byte of word i accepted in cycle t → `mem_we`=1, `mem_addr`=i, `mem_wdata`=word in t+1. `mem_we` is low otherwise.
- Back-to-back bytes (one per cycle) are sustained with no bubbles; the write of word i overlaps byte 0 of word i+1.
- Last checksum byte, or 4th length byte on overflow, accepted in cycle t → `done` or `error` high in t+1, with `busy` and `byte_ready` low.
- `byte_valid` gaps of any length are tolerated; state holds.

## Structure
- `riscv_pkg` holds:
  - `XLEN` and `MEM_SIZE`
  - a new `loader_state_e` enum (IDLE, LEN, DATA, CHECK, DONE, ERR)
  - `LOADER_MAX_WORDS` = `MEM_SIZE`
- No sub-module is required. An optional `byte_packer` (byte counter plus 32-bit shift assembler, emitting `word_valid`) is reused for the three fields.

## Test plan
- **Reset:** assert `rst` → all outputs at reset values, `byte_ready`=0. `byte_valid`=1 in IDLE is not consumed.
- **Two-word load, one byte per cycle:**
  - Stimulus: `start`, then bytes 02 00 00 00 | 93 00 50 00 | 13 01 10 00 | A6 01 60 00.
  - Writes: addr 0 = 0x00500093, addr 1 = 0x00100113, one cycle after each 4th byte.
  - Then `done`=1 and `core_hold`=0.
- **Same image, last checksum byte 01 instead of 00:** `error`=1, `core_hold` stays 1, both writes still occurred.
- **Length overflow:** N = MEM_SIZE+1 (bytes 01 04 00 00) → `error`=1 the cycle after the 4th byte, `byte_ready`=0, no `mem_we` ever.
- **Empty image:** N=0, checksum 00 00 00 00 → `done`=1, no writes. Repeat with random `byte_valid` gaps; results identical.
- **Reset mid-DATA:** assert `rst` after 2 bytes of word 0 → no write occurs, state IDLE. A fresh `start` plus the two-word image then completes with `done`=1.
